// File: rtl/host_cmd_framer.sv
// host_cmd_framer: turns the uart_rx byte stream into validated host command frames with a valid/ready handoff.
// Define HOST_FRAMER_STATS_EN to build saturating frame/error counters; otherwise both counter ports read zero.
module host_cmd_framer #(
  parameter int CLKS_PER_BIT  = 5208,
  parameter int TIMEOUT_BYTES = 2,
  parameter int MAX_BYTES     = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             i_rx_byte,
  input  logic                   i_rx_dv,
  output logic [8*MAX_BYTES-1:0] o_frame,
  output logic [3:0]             o_frame_len,
  output logic                   o_frame_valid,
  input  logic                   i_frame_ready,
  output logic                   o_err,
  output logic [2:0]             o_err_code,
  output logic [15:0]            o_frame_count,
  output logic [15:0]            o_err_count
);

  localparam int FW      = 8 * MAX_BYTES;
  localparam int TIMEOUT = CLKS_PER_BIT * 10 * TIMEOUT_BYTES;
  localparam int TW      = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  localparam logic [7:0] OP_ENCRYPT  = 8'h01;
  localparam logic [7:0] OP_YAW      = 8'h03;
  localparam logic [3:0] LEN_ENCRYPT = 4'd11;
  localparam logic [3:0] LEN_YAW     = 4'd7;

  localparam logic [2:0] ERR_OPCODE  = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT = 3'd2;
  localparam logic [2:0] ERR_OVERRUN = 3'd3;
  localparam logic [2:0] ERR_TRAILER = 3'd4;

  logic [1:0]    state_q;
  logic [3:0]    idx_q;
  logic [TW-1:0] tcnt_q;

  logic [3:0] exp_len;
  logic       opcode_ok;
  logic       last_byte;
  logic       trailer_ok;
  logic       handoff;
  logic       start_byte;

  // The opcode always sits in byte 0 of the buffer once collection has started.
  assign exp_len    = (o_frame[7:0] == OP_ENCRYPT) ? LEN_ENCRYPT : LEN_YAW;
  assign opcode_ok  = (i_rx_byte == OP_ENCRYPT) || (i_rx_byte == OP_YAW);
  assign last_byte  = (idx_q == exp_len - 4'd1);
  assign trailer_ok = (o_frame[7:0] != OP_ENCRYPT) ||
                      ((o_frame[79:72] == 8'hBE) && (i_rx_byte == 8'hEF));
  assign handoff    = (state_q == HOLD) && i_frame_ready;
  assign start_byte = i_rx_dv && ((state_q == IDLE) || handoff);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      tcnt_q        <= '0;
      o_frame       <= '0;
      o_frame_len   <= '0;
      o_frame_valid <= 1'b0;
      o_err         <= 1'b0;
      o_err_code    <= '0;
    end else begin
      o_err <= 1'b0;
      case (state_q)
        IDLE: begin
        end
        COLLECT: begin
          if (i_rx_dv) begin
            tcnt_q <= '0;
            if (last_byte) begin
              if (trailer_ok) begin
                o_frame[{idx_q, 3'b000} +: 8] <= i_rx_byte;
                o_frame_len   <= exp_len;
                o_frame_valid <= 1'b1;
                state_q       <= HOLD;
              end else begin
                o_frame    <= '0;
                idx_q      <= '0;
                o_err      <= 1'b1;
                o_err_code <= ERR_TRAILER;
                state_q    <= IDLE;
              end
            end else begin
              o_frame[{idx_q, 3'b000} +: 8] <= i_rx_byte;
              idx_q <= idx_q + 4'd1;
            end
          end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
            o_frame    <= '0;
            idx_q      <= '0;
            tcnt_q     <= '0;
            o_err      <= 1'b1;
            o_err_code <= ERR_TIMEOUT;
            state_q    <= IDLE;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (i_frame_ready) begin
            o_frame       <= '0;
            o_frame_len   <= '0;
            o_frame_valid <= 1'b0;
            idx_q         <= '0;
            state_q       <= IDLE;
          end else if (i_rx_dv) begin
            o_err      <= 1'b1;
            o_err_code <= ERR_OVERRUN;
          end
        end
        default: begin
          o_frame       <= '0;
          o_frame_len   <= '0;
          o_frame_valid <= 1'b0;
          idx_q         <= '0;
          tcnt_q        <= '0;
          state_q       <= IDLE;
        end
      endcase

      // Opcode bytes are decoded here so a byte landing on the handoff cycle starts the next frame.
      if (start_byte) begin
        if (opcode_ok) begin
          o_frame <= FW'(i_rx_byte);
          idx_q   <= 4'd1;
          tcnt_q  <= '0;
          state_q <= COLLECT;
        end else begin
          o_err      <= 1'b1;
          o_err_code <= ERR_OPCODE;
        end
      end
    end
  end

`ifdef HOST_FRAMER_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] err_cnt_q;

  // Both counters saturate rather than wrap so a long soak run never reports a misleading small value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (handoff && (frame_cnt_q != 16'hFFFF))
        frame_cnt_q <= frame_cnt_q + 16'd1;
      if (o_err && (err_cnt_q != 16'hFFFF))
        err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign o_frame_count = frame_cnt_q;
  assign o_err_count   = err_cnt_q;
`else
  assign o_frame_count = 16'h0000;
  assign o_err_count   = 16'h0000;
`endif

endmodule

// File: tb/tb_host_cmd_framer.sv
// Directed-vector bench for host_cmd_framer; runs with a short UART bit period so the timeout fits in a brief run.
module tb_host_cmd_framer;

  localparam int CLKS_PER_BIT  = 20;
  localparam int TIMEOUT_BYTES = 2;
  localparam int TIMEOUT       = CLKS_PER_BIT * 10 * TIMEOUT_BYTES;

  logic        clk;
  logic        reset;
  logic [7:0]  i_rx_byte;
  logic        i_rx_dv;
  logic [87:0] o_frame;
  logic [3:0]  o_frame_len;
  logic        o_frame_valid;
  logic        i_frame_ready;
  logic        o_err;
  logic [2:0]  o_err_code;
  logic [15:0] o_frame_count;
  logic [15:0] o_err_count;

  int assert_count = 0;
  int fail_count   = 0;
  int err_pulses   = 0;

  logic [7:0] tx_q[$];

  host_cmd_framer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .TIMEOUT_BYTES(TIMEOUT_BYTES),
    .MAX_BYTES    (11)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_rx_byte    (i_rx_byte),
    .i_rx_dv      (i_rx_dv),
    .o_frame      (o_frame),
    .o_frame_len  (o_frame_len),
    .o_frame_valid(o_frame_valid),
    .i_frame_ready(i_frame_ready),
    .o_err        (o_err),
    .o_err_code   (o_err_code),
    .o_frame_count(o_frame_count),
    .o_err_count  (o_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // o_err is a one-clock strobe, so one sample per negedge counts each pulse exactly once.
  always @(negedge clk) begin
    if (o_err === 1'b1) err_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [87:0] actual, input logic [87:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Called on a negedge; the following posedge consumes the inputs and it returns on the next negedge.
  task automatic applyStimulus(input logic [7:0] b, input logic dv, input logic rdy);
    i_rx_byte     = b;
    i_rx_dv       = dv;
    i_frame_ready = rdy;
    @(negedge clk);
  endtask

  task automatic sendBytes();
    for (int i = 0; i < tx_q.size(); i++)
      applyStimulus(tx_q[i], 1'b1, 1'b0);
  endtask

  task automatic handshake();
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    reset         = 1'b0;
    i_rx_byte     = 8'h00;
    i_rx_dv       = 1'b0;
    i_frame_ready = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("reset_frame", o_frame, 88'h0);
    checkOutput("reset_len", 88'(o_frame_len), 88'h0);
    checkOutput("reset_valid", 88'(o_frame_valid), 88'h0);
    checkOutput("reset_err", 88'(o_err), 88'h0);
    checkOutput("reset_code", 88'(o_err_code), 88'h0);
    checkOutput("reset_counts", 88'({o_frame_count, o_err_count}), 88'h0);
    reset = 1'b1;
    @(negedge clk);

    // ENCRYPT_ENABLE held for 50 clocks before the consumer takes it
    tx_q = {8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h01, 8'hBE};
    sendBytes();
    checkOutput("enc_valid_early", 88'(o_frame_valid), 88'h0);
    applyStimulus(8'hEF, 1'b1, 1'b0);
    checkOutput("enc_valid", 88'(o_frame_valid), 88'h1);
    checkOutput("enc_frame", o_frame, 88'hEFBE0101FFFFFFFFFFFF01);
    checkOutput("enc_len", 88'(o_frame_len), 88'd11);
    repeat (50) applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("enc_hold_valid", 88'(o_frame_valid), 88'h1);
    checkOutput("enc_hold_frame", o_frame, 88'hEFBE0101FFFFFFFFFFFF01);
    applyStimulus(8'h00, 1'b0, 1'b1);
    checkOutput("enc_accept_valid", 88'(o_frame_valid), 88'h0);
    checkOutput("enc_accept_frame", o_frame, 88'h0);
    applyStimulus(8'h00, 1'b0, 1'b0);

    // READ_YAW: short frame, upper bytes must be zero
    tx_q = {8'h03, 8'h27, 8'hFF, 8'h27, 8'hFF, 8'h27, 8'hFF};
    sendBytes();
    checkOutput("yaw_valid", 88'(o_frame_valid), 88'h1);
    checkOutput("yaw_frame", o_frame, 88'h00000000FF27FF27FF2703);
    checkOutput("yaw_len", 88'(o_frame_len), 88'd7);
    checkOutput("yaw_no_err", 88'(err_pulses), 88'd0);
    handshake();

    // Bad opcodes
    applyStimulus(8'h05, 1'b1, 1'b0);
    checkOutput("badop1_err", 88'(o_err), 88'h1);
    checkOutput("badop1_code", 88'(o_err_code), 88'd1);
    applyStimulus(8'h27, 1'b1, 1'b0);
    checkOutput("badop2_err", 88'(o_err), 88'h1);
    checkOutput("badop2_code", 88'(o_err_code), 88'd1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("badop_pulses", 88'(err_pulses), 88'd2);
    checkOutput("badop_frame", o_frame, 88'h0);
    checkOutput("badop_valid", 88'(o_frame_valid), 88'h0);

    // Truncated frame times out exactly TIMEOUT idle clocks after the last byte
    tx_q = {8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h27, 8'hFF, 8'hFF, 8'h01, 8'h00};
    sendBytes();
    repeat (TIMEOUT - 1) applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("to_pre_err", 88'(o_err), 88'h0);
    checkOutput("to_pre_frame", o_frame, 88'h0001FFFF27FFFFFF01);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("to_err", 88'(o_err), 88'h1);
    checkOutput("to_code", 88'(o_err_code), 88'd2);
    checkOutput("to_frame", o_frame, 88'h0);

    // A byte on the limit cycle beats the timeout
    tx_q = {8'h03, 8'h27};
    sendBytes();
    repeat (TIMEOUT - 1) applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h11, 1'b1, 1'b0);
    checkOutput("to_win_err", 88'(o_err), 88'h0);
    checkOutput("to_win_frame", o_frame, 88'h112703);
    tx_q = {8'h22, 8'h33, 8'h44, 8'h55};
    sendBytes();
    checkOutput("to_win_done", o_frame, 88'h00000000554433221127 << 8 | 88'h03);
    handshake();

    // ENCRYPT_DISABLE parses cleanly after the timeout
    tx_q = {8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'hBE, 8'hEF};
    sendBytes();
    checkOutput("dis_frame", o_frame, 88'hEFBE0001FFFFFFFFFFFF01);
    checkOutput("dis_valid", 88'(o_frame_valid), 88'h1);
    handshake();

    // Bad trailer
    tx_q = {8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h01, 8'hBE, 8'hEE};
    sendBytes();
    checkOutput("trl_err", 88'(o_err), 88'h1);
    checkOutput("trl_code", 88'(o_err_code), 88'd4);
    checkOutput("trl_valid", 88'(o_frame_valid), 88'h0);
    checkOutput("trl_frame", o_frame, 88'h0);

    // Overrun while holding, then a byte on the same cycle as ready
    tx_q = {8'h03, 8'h27, 8'hFF, 8'h27, 8'hFF, 8'h27, 8'hFF};
    sendBytes();
    applyStimulus(8'h42, 1'b1, 1'b0);
    checkOutput("ovr_err", 88'(o_err), 88'h1);
    checkOutput("ovr_code", 88'(o_err_code), 88'd3);
    checkOutput("ovr_frame", o_frame, 88'h00000000FF27FF27FF2703);
    checkOutput("ovr_valid", 88'(o_frame_valid), 88'h1);
    applyStimulus(8'h03, 1'b1, 1'b1);
    checkOutput("same_err", 88'(o_err), 88'h0);
    checkOutput("same_valid", 88'(o_frame_valid), 88'h0);
    checkOutput("same_frame", o_frame, 88'h03);
    tx_q = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    sendBytes();
    checkOutput("same_done", o_frame, 88'h00000000A6A5A4A3A2A103);
    checkOutput("same_done_valid", 88'(o_frame_valid), 88'h1);
    handshake();

    // Reset in the middle of a frame clears everything without an error
    tx_q = {8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    sendBytes();
    reset   = 1'b0;
    i_rx_dv = 1'b0;
    #1;
    checkOutput("mid_rst_frame", o_frame, 88'h0);
    checkOutput("mid_rst_code", 88'(o_err_code), 88'h0);
    checkOutput("mid_rst_counts", 88'({o_frame_count, o_err_count}), 88'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tx_q = {8'h03, 8'h27, 8'hFF, 8'h27, 8'hFF, 8'h27, 8'hFF};
    sendBytes();
    checkOutput("post_rst_frame", o_frame, 88'h00000000FF27FF27FF2703);
    checkOutput("post_rst_len", 88'(o_frame_len), 88'd7);
    handshake();
`ifdef HOST_FRAMER_STATS_EN
    checkOutput("stats_frames", 88'(o_frame_count), 88'd1);
`else
    checkOutput("stats_frames", 88'(o_frame_count), 88'd0);
`endif
    checkOutput("stats_errs", 88'(o_err_count), 88'd0);
    checkOutput("total_err_pulses", 88'(err_pulses), 88'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
